sdram_bram_responder: RTL and testbench

- Drop-in responder for the internal SDRAM request/ack interface that the write/read FIFO controller drives.
- It services write and read burst requests from an on-chip block RAM instead of external SDRAM.
- SDRAM timing (init delay, activate latency, CAS latency, periodic refresh stalls) is emulated with parameterised counters.
- Used for SDRAM-less builds and for closed-loop simulation of the FIFO controller.

---
 rtl/sdram_bram_responder.sv | 130 +++++++++++++
 tb/tb_sdram_bram_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM request/ack port of the FIFO controller.
// Emulates init, activate, CAS latency and refresh stalls with counters.
module sdram_bram_responder #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned INIT_CYCLES = 200,
   parameter int unsigned ACT_LAT     = 3,
   parameter int unsigned CAS_LAT     = 2,
   parameter int unsigned REF_PERIOD  = 780,
   parameter int unsigned REF_CYCLES  = 8
) (
   input  logic        clk_ref,
   input  logic        rst,
   input  logic        sdram_wr_req,
   input  logic        sdram_rd_req,
   input  logic [21:0] sys_wraddr,
   input  logic [21:0] sys_rdaddr,
   input  logic [8:0]  sdwr_byte,
   input  logic [8:0]  sdrd_byte,
   input  logic [15:0] sys_data_in,
   output logic        sdram_wr_ack,
   output logic        sdram_rd_ack,
   output logic [15:0] sys_data_out,
   output logic        sdram_init_done
);

   typedef enum logic [3:0] {
      INIT, IDLE, REF, WACT, WR, WTAIL, RACT, RLAT, RD, GAP
   } state_t;

   state_t            state, nxt;
   logic [31:0]       cnt;
   logic [31:0]       ref_cnt;
   logic [9:0]        rem;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] wa;
   logic              we;
   logic              ref_pend;
   logic              tie_rd;
   logic              grant_wr;
   logic              grant_rd;
   logic              ref_hit;
   logic              unused;
   logic [15:0]       mem [2**ADDR_W];

   assign unused  = ^{sys_wraddr[21:ADDR_W], sys_rdaddr[21:ADDR_W]};
   assign ref_hit = sdram_init_done && (ref_cnt == REF_PERIOD - 1);

   always_comb begin
      nxt          = state;
      grant_wr     = 1'b0;
      grant_rd     = 1'b0;
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      unique case (state)
         INIT: if (cnt == INIT_CYCLES - 1) nxt = IDLE;
         IDLE: begin
            // refresh wins; ties alternate, starting with write
            if (ref_pend) begin
               nxt = REF;
            end else if (sdram_wr_req && !(sdram_rd_req && tie_rd)) begin
               grant_wr = 1'b1;
               nxt      = WACT;
            end else if (sdram_rd_req) begin
               grant_rd = 1'b1;
               nxt      = RACT;
            end
         end
         REF:  if (cnt == REF_CYCLES - 1) nxt = IDLE;
         WACT: if (cnt == ACT_LAT - 1) nxt = WR;
         WR: begin
            sdram_wr_ack = 1'b1;
            if (rem == 10'd1) nxt = WTAIL;
         end
         WTAIL: nxt = GAP;
         RACT: if (cnt == ACT_LAT - 1) nxt = RLAT;
         RLAT: if (cnt == CAS_LAT - 1) nxt = RD;
         RD: begin
            sdram_rd_ack = 1'b1;
            if (rem == 10'd1) nxt = GAP;
         end
         GAP: nxt = IDLE;
         default: nxt = INIT;
      endcase
   end

   always_ff @(posedge clk_ref) begin
      if (rst) begin
         state           <= INIT;
         cnt             <= '0;
         ref_cnt         <= '0;
         ref_pend        <= 1'b0;
         sdram_init_done <= 1'b0;
         tie_rd          <= 1'b0;
         rem             <= '0;
         addr            <= '0;
         we              <= 1'b0;
         wa              <= '0;
         sys_data_out    <= '0;
      end else begin
         state <= nxt;
         cnt   <= (nxt != state) ? 32'd0 : cnt + 32'd1;
         if (state == INIT && nxt == IDLE) sdram_init_done <= 1'b1;
         if (sdram_init_done)
            ref_cnt <= ref_hit ? 32'd0 : ref_cnt + 32'd1;
         if (state == REF && nxt == IDLE) ref_pend <= 1'b0;
         if (ref_hit) ref_pend <= 1'b1;
         if ((grant_wr || grant_rd) && sdram_wr_req && sdram_rd_req)
            tie_rd <= !tie_rd;
         if (grant_wr) begin
            addr <= sys_wraddr[ADDR_W-1:0];
            rem  <= (sdwr_byte == 9'd0) ? 10'd512 : {1'b0, sdwr_byte};
         end else if (grant_rd) begin
            addr <= sys_rdaddr[ADDR_W-1:0];
            rem  <= (sdrd_byte == 9'd0) ? 10'd512 : {1'b0, sdrd_byte};
         end else begin
            if (state == WR || nxt == RD) addr <= addr + ADDR_W'(1);
            if (state == WR || state == RD) rem <= rem - 10'd1;
         end
         // data for an ack arrives one cycle later
         we <= (state == WR);
         wa <= addr;
         if (nxt == RD) sys_data_out <= mem[addr];
      end
   end

   always_ff @(posedge clk_ref) begin
      if (we) mem[wa] <= sys_data_in;
   end

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for sdram_bram_responder: init, bursts, ties, wrap,
// refresh stall and reset mid-burst.
module tb_sdram_bram_responder;

   logic        clk_ref;
   logic        rst;
   logic        sdram_wr_req;
   logic        sdram_rd_req;
   logic [21:0] sys_wraddr;
   logic [21:0] sys_rdaddr;
   logic [8:0]  sdwr_byte;
   logic [8:0]  sdrd_byte;
   logic [15:0] sys_data_in;
   logic        sdram_wr_ack;
   logic        sdram_rd_ack;
   logic [15:0] sys_data_out;
   logic        sdram_init_done;

   sdram_bram_responder dut (
      .clk_ref         (clk_ref),
      .rst             (rst),
      .sdram_wr_req    (sdram_wr_req),
      .sdram_rd_req    (sdram_rd_req),
      .sys_wraddr      (sys_wraddr),
      .sys_rdaddr      (sys_rdaddr),
      .sdwr_byte       (sdwr_byte),
      .sdrd_byte       (sdrd_byte),
      .sys_data_in     (sys_data_in),
      .sdram_wr_ack    (sdram_wr_ack),
      .sdram_rd_ack    (sdram_rd_ack),
      .sys_data_out    (sys_data_out),
      .sdram_init_done (sdram_init_done)
   );

   initial clk_ref = 1'b0;
   always #5 clk_ref = ~clk_ref;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          overlap = 0;
   logic        prev_wa = 1'b0;
   logic [15:0] wq[$];
   logic [15:0] rq[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_ref);
      #1;
      cyc++;
      if (prev_wa) begin
         if (wq.size() > 0) sys_data_in = wq.pop_front();
         else sys_data_in = 16'h0;
      end
      prev_wa = sdram_wr_ack;
      if (sdram_rd_ack) rq.push_back(sys_data_out);
      if (sdram_wr_ack && sdram_rd_ack) overlap++;
   endtask

   task automatic do_write(input logic [21:0] a, input logic [8:0] n,
                           input logic [15:0] base, input int tail,
                           output int lat, output int acks);
      int len;
      int t0;
      len = (n == 9'd0) ? 512 : int'(n);
      for (int i = 0; i < len; i++) wq.push_back(16'(base + i));
      sys_wraddr   = a;
      sdwr_byte    = n;
      sdram_wr_req = 1'b1;
      t0   = cyc;
      lat  = -1;
      acks = 0;
      for (int k = 0; k < 2000; k++) begin
         tick();
         if (sdram_wr_ack) begin
            if (acks == 0) begin
               lat = cyc - t0;
               sdram_wr_req = 1'b0;
            end
            acks++;
         end else if (acks > 0) begin
            break;
         end
      end
      sdram_wr_req = 1'b0;
      repeat (tail) tick();
   endtask

   task automatic do_read(input logic [21:0] a, input logic [8:0] n,
                          input int tail, output int lat, output int acks);
      int t0;
      rq.delete();
      sys_rdaddr   = a;
      sdrd_byte    = n;
      sdram_rd_req = 1'b1;
      t0   = cyc;
      lat  = -1;
      acks = 0;
      for (int k = 0; k < 2000; k++) begin
         tick();
         if (sdram_rd_ack) begin
            if (acks == 0) begin
               lat = cyc - t0;
               sdram_rd_req = 1'b0;
            end
            acks++;
         end else if (acks > 0) begin
            break;
         end
      end
      sdram_rd_req = 1'b0;
      repeat (tail) tick();
   endtask

   task automatic do_pair(input logic [21:0] raddr, input logic [15:0] base,
                          output logic wr_first, output int wa_n,
                          output int ra_n);
      rq.delete();
      wq.push_back(base);
      wq.push_back(16'(base + 1));
      sys_wraddr   = 22'h000020;
      sdwr_byte    = 9'd2;
      sys_rdaddr   = raddr;
      sdrd_byte    = 9'd2;
      sdram_wr_req = 1'b1;
      sdram_rd_req = 1'b1;
      wr_first = 1'b0;
      wa_n = 0;
      ra_n = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (sdram_wr_ack) begin
            if (wa_n == 0 && ra_n == 0) wr_first = 1'b1;
            sdram_wr_req = 1'b0;
            wa_n++;
         end
         if (sdram_rd_ack) begin
            sdram_rd_req = 1'b0;
            ra_n++;
         end
         if (wa_n >= 2 && ra_n >= 2 && !sdram_wr_ack && !sdram_rd_ack) break;
      end
      sdram_wr_req = 1'b0;
      sdram_rd_req = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int   lat;
      int   acks;
      int   n;
      int   init_acks;
      int   tinit;
      logic wf;
      int   wa_n;
      int   ra_n;

      rst          = 1'b1;
      sdram_wr_req = 1'b0;
      sdram_rd_req = 1'b0;
      sys_wraddr   = '0;
      sys_rdaddr   = '0;
      sdwr_byte    = '0;
      sdrd_byte    = '0;
      sys_data_in  = '0;
      repeat (3) tick();
      chk("reset_outs", {sdram_wr_ack, sdram_rd_ack, sdram_init_done,
                         sys_data_out}, 32'h0);

      // init window with an early request that must be ignored
      rst = 1'b0;
      n = 0;
      init_acks = 0;
      while (!sdram_init_done && n < 1000) begin
         tick();
         n++;
         if (n == 50) begin
            sys_wraddr   = 22'h000200;
            sdwr_byte    = 9'd1;
            sdram_wr_req = 1'b1;
         end
         if (sdram_wr_ack) init_acks++;
      end
      sdram_wr_req = 1'b0;
      tinit = cyc;
      chk("init_cycles", n, 200);
      chk("init_no_ack", init_acks, 0);

      do_write(22'h000010, 9'd8, 16'hA000, 4, lat, acks);
      chk("wr8_lat", lat, 4);
      chk("wr8_acks", acks, 8);
      do_read(22'h000010, 9'd8, 4, lat, acks);
      chk("rd8_lat", lat, 6);
      chk("rd8_acks", acks, 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rd8_d%0d", i), rq[i], 32'(16'hA000 + i));

      do_pair(22'h000010, 16'hC000, wf, wa_n, ra_n);
      chk("tie1_wr_first", wf, 1'b1);
      chk("tie1_counts", {wa_n[15:0], ra_n[15:0]}, {16'd2, 16'd2});
      chk("tie1_rd_d0", rq[0], 16'hA000);
      do_pair(22'h000020, 16'hE000, wf, wa_n, ra_n);
      chk("tie2_wr_first", wf, 1'b0);
      chk("tie2_counts", {wa_n[15:0], ra_n[15:0]}, {16'd2, 16'd2});
      chk("tie2_rd_d0", rq[0], 16'hC000);
      chk("tie2_rd_d1", rq[1], 16'hC001);

      // upper address bits ignored; burst wraps past 0xFFF
      do_write(22'h3FFFFE, 9'd4, 16'hB000, 4, lat, acks);
      chk("wrap_wr_acks", acks, 4);
      do_read(22'h000FFE, 9'd4, 4, lat, acks);
      chk("wrap_rd_acks", acks, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("wrap_d%0d", i), rq[i], 32'(16'hB000 + i));
      do_read(22'h000000, 9'd2, 4, lat, acks);
      chk("wrap_low_d0", rq[0], 16'hB002);
      chk("wrap_low_d1", rq[1], 16'hB003);

      // 512-word read straddling the first refresh request
      while (cyc - tinit < 400) tick();
      do_read(22'h000000, 9'd0, 0, lat, acks);
      chk("long_lat", lat, 6);
      chk("long_acks", acks, 512);
      chk("long_d0", rq[0], 16'hB002);
      chk("long_d16", rq[16], 16'hA000);
      chk("long_d23", rq[23], 16'hA007);

      // refresh inserted before the next grant, then reset on word 3
      for (int i = 0; i < 16; i++) wq.push_back(16'(16'hD000 + i));
      sys_wraddr   = 22'h000100;
      sdwr_byte    = 9'd16;
      sdram_wr_req = 1'b1;
      n    = cyc;
      lat  = -1;
      acks = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (sdram_wr_ack) begin
            if (acks == 0) begin
               lat = cyc - n;
               sdram_wr_req = 1'b0;
            end
            acks++;
            if (acks == 3) begin
               rst = 1'b1;
               break;
            end
         end
      end
      chk("ref_lat", lat, 14);
      tick();
      chk("rst_wr_ack", sdram_wr_ack, 1'b0);
      chk("rst_init", sdram_init_done, 1'b0);
      rst = 1'b0;
      sdram_wr_req = 1'b0;
      wq.delete();
      n = 0;
      while (!sdram_init_done && n < 1000) begin
         tick();
         n++;
      end
      chk("init2_cycles", n, 200);

      do_read(22'h000010, 9'd8, 4, lat, acks);
      chk("keep_lat", lat, 6);
      chk("keep_acks", acks, 8);
      chk("keep_d0", rq[0], 16'hA000);
      chk("keep_d7", rq[7], 16'hA007);

      chk("ack_overlap", overlap, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
